// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int WORD_W      = 32;
  localparam int BE_W        = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Expands per-byte enables into a per-bit write mask.
  function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Word-wide storage bank: synchronous byte-enabled write, asynchronous read.
// Only one access is ever in flight, so a single address serves both ports.
module mem_bank_be
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mask;

  assign mask    = be_mask(be_i);
  assign rdata_o = mem_q[addr_i];

  // Merge enabled byte lanes into the addressed word; storage is never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~mask) | (wdata_i & mask);
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Slave end of the load/store interface: one word request at a time,
// fixed wait-state latency, byte-enabled writes, misalign/range faults.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | counting down the wait states; access happens when count is 1
// RESP  | response presented, held until the requester takes it
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              addr_err;
  logic              access;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] mem_rdata;

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[WORD_W-1:2] >= 30'(DEPTH));
  assign idx      = addr_q[IDX_W+1:2];
  assign access   = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  // A reset landing on the access edge must cancel the write.
  assign mem_we   = access && we_q && !addr_err && !reset;

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  mem_bank_be #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (mem_rdata)
  );

  // State, counter, latched request and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshake outputs and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_W'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (access) begin
          err_d   = addr_err;
          rdata_d = (addr_err || we_q) ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, randomized traffic
// against a word/byte-lane reference model, and hand-built corner sequences.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word array addressed by byte address / 4, written lane by lane.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rd, output logic err);
    logic [31:0] w;
    w   = addr / 4;
    err = (addr % 4 != 0) || (w >= DEPTH);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = ref_mem[w];
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    chk("req_ready_idle", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the first falling edge after acceptance; n counts that edge as 1.
  task automatic wait_resp(output int n);
    int busy_rdy;
    n = 1;
    busy_rdy = 0;
    while (!resp_valid && n < 40) begin
      if (req_ready) busy_rdy++;
      @(negedge clk);
      n++;
    end
    chk("req_ready_busy", 32'(busy_rdy), 32'h0);
    chk("req_ready_resp", 32'(req_ready), 32'h0);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", 32'(resp_valid), 32'h0);
    chk("req_ready_after_hs", 32'(req_ready), 32'h1);
    chk("rdata_cleared", resp_rdata, 32'h0);
    chk("err_cleared", 32'(resp_err), 32'h0);
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall,
                        output logic [31:0] rd, output logic err);
    int n;
    int unstable;
    issue(we, addr, wdata, be);
    wait_resp(n);
    chk("latency", 32'(n), 32'(LAT + 1));
    rd = resp_rdata;
    err = resp_err;
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_rdata !== rd || resp_err !== err) unstable++;
    end
    chk("resp_stable", 32'(unstable), 32'h0);
    finish_resp();
  endtask

  task automatic run_model(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic [31:0] exp_rd, rd;
    logic exp_err, err;
    model(we, addr, wdata, be, exp_rd, exp_err);
    do_txn(we, addr, wdata, be, stall, rd, err);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, exp_rd;
    logic err, exp_err;
    int n;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      run_model("init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h11,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 32'h14,  32'h00000000, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h14,  32'h12345678, 4'hA, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        4'h0, 32'h12005600, 1'b0});
    vecs.push_back('{1'b1, 32'hFC,  32'hCAFE0001, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFC,  32'h0,        4'h0, 32'hCAFE0001, 1'b0});
    vecs.push_back('{1'b0, 32'h101, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1});

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp_rd, exp_err);
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 3, rd, err);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      case ($urandom_range(0, 9))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
        2: a = $urandom;
        default: ;
      endcase
      run_model("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    for (int i = 0; i < DEPTH; i++)
      run_model("sweep", 1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

    // Back-pressure: response held 5 cycles with a new request waiting.
    model(1'b0, 32'h10, 32'h0, 4'h0, exp_rd, exp_err);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(n);
    chk("bp_latency", 32'(n), 32'(LAT + 1));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_rdata", resp_rdata, exp_rd);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_hs_req_ready", 32'(req_ready), 32'h1);
    chk("bp_hs_resp_valid", 32'(resp_valid), 32'h0);
    chk("bp_hs_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_accepted", 32'(req_ready), 32'h0);
    model(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, exp_rd, exp_err);
    wait_resp(n);
    chk("bp_next_latency", 32'(n), 32'(LAT + 1));
    chk("bp_next_err", 32'(resp_err), 32'h0);
    finish_resp();
    run_model("bp_readback", 1'b0, 32'h14, 32'h0, 4'h0, 0);

    // Reset early in BUSY: write to 0x20 is dropped.
    issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst1_req_ready", 32'(req_ready), 32'h1);
    chk("rst1_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst1_rdata", resp_rdata, 32'h0);
    chk("rst1_err", 32'(resp_err), 32'h0);
    run_model("rst1_readback", 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Reset exactly on the access edge: write to 0x20 still dropped.
    issue(1'b1, 32'h20, 32'h5EED5EED, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_req_ready", 32'(req_ready), 32'h1);
    chk("rst2_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst2_rdata", resp_rdata, 32'h0);
    chk("rst2_err", 32'(resp_err), 32'h0);
    run_model("rst2_readback", 1'b0, 32'h20, 32'h0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
